// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and write-back requester indices
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int REG_NUM = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam int WB_ALU = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_MUL = 2;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: issue, write-back request and register-file write bundle
//   master: issue stage / execution units / testbench side
//   slave : regfile_wb_sched side
interface regfile_wb_sched_if #(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32
);
  logic                 issue_valid;
  logic [AW-1:0]        issue_dest;
  logic [AW-1:0]        issue_src1;
  logic [AW-1:0]        issue_src2;
  logic                 issue_stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        writeData;
  logic [AW-1:0]        writeAdd;
  logic                 writeEn;
  logic [(1<<AW)-1:0]   busy;
  modport master (
    output issue_valid, issue_dest, issue_src1, issue_src2, req_valid, req_addr, req_data,
    input  issue_stall, req_ready, writeData, writeAdd, writeEn, busy
  );
  modport slave (
    input  issue_valid, issue_dest, issue_src1, issue_src2, req_valid, req_addr, req_data,
    output issue_stall, req_ready, writeData, writeAdd, writeEn, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter, search starts after the last grant
//   clk, rst_n : clock, async active-low reset (last resets to N-1)
//   req        : request vector
//   gnt        : one-hot grant, zero when no request
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int LW = N > 1 ? $clog2(N) : 1;
  logic [LW-1:0] r_last;
  logic [LW-1:0] w_idx;
  logic [LW-1:0] w_cand;
  // Walk from lowest to highest priority so the nearest valid requester wins.
  always_comb begin
    gnt = '0;
    w_idx = r_last;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = LW'((int'(r_last) + k) % N);
      if (req[w_cand]) begin
        gnt = '0;
        gnt[w_cand] = 1'b1;
        w_idx = w_cand;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= LW'(N - 1);
    else if (|req) r_last <= w_idx;
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-back port scheduler with RAW/WAW busy scoreboard
//   clk, rst_n : clock, async active-low reset
//   bus        : issue inputs / issue_stall, write-back requests / req_ready,
//                registered register-file write port and busy scoreboard
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_sched_if.slave bus
);
  localparam int NR = 1 << AW;
  logic [NREQ-1:0] w_gnt;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            w_xfer;
  logic            w_acc;
  logic [NR-1:0]   w_set;
  logic [NR-1:0]   w_clr;
  logic [NR-1:0]   r_busy;
  logic            r_we;
  logic [AW-1:0]   r_wadd;
  logic [DW-1:0]   r_wdata;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .gnt   (w_gnt)
  );
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) begin
        w_addr = bus.req_addr[i*AW +: AW];
        w_data = bus.req_data[i*DW +: DW];
      end
  end
  assign w_xfer = |w_gnt;
  assign bus.req_ready = w_gnt;
  assign bus.issue_stall = bus.issue_valid &
    (r_busy[bus.issue_src1] | r_busy[bus.issue_src2] | r_busy[bus.issue_dest]);
  // r0 is hard-wired zero: never marked busy, never written.
  assign w_acc = bus.issue_valid & ~bus.issue_stall & (bus.issue_dest != REG_ZERO);
  assign w_set = w_acc ? NR'(1) << bus.issue_dest : '0;
  // Clear on the edge where the register file captures the write.
  assign w_clr = r_we ? NR'(1) << r_wadd : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wadd <= '0;
      r_wdata <= '0;
      r_busy <= '0;
    end else begin
      r_we <= w_xfer & (w_addr != REG_ZERO);
      if (w_xfer) begin
        r_wadd <= w_addr;
        r_wdata <= w_data;
      end
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  assign bus.writeEn = r_we;
  assign bus.writeAdd = r_wadd;
  assign bus.writeData = r_wdata;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed tests for the write-back scheduler and scoreboard
module tb_regfile_wb_sched;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] rf [32];
  logic [31:0] rr_data [3];
  regfile_wb_sched_if #(.NREQ(3), .AW(5), .DW(32)) bus ();
  regfile_wb_sched #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.writeEn) rf[bus.writeAdd] <= bus.writeData;

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*5 +: 5] = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    bus.issue_valid = v;
    bus.issue_dest = d;
    bus.issue_src1 = s1;
    bus.issue_src2 = s2;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (bus.writeEn !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.writeEn); end
    n_tests++; if (bus.writeAdd !== 5'd0) begin n_fail++; $display("FAIL reset_wadd got=%0d exp=0", bus.writeAdd); end
    n_tests++; if (bus.writeData !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.writeData); end
    n_tests++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", bus.busy); end
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), rr_data[i]);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      e = k % 3;
      #1;
      n_tests++; if (bus.req_ready !== 3'(1 << e)) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, bus.req_ready, 3'(1 << e)); end
      @(negedge clk);
      n_tests++; if (bus.writeEn !== 1'b1 || bus.writeAdd !== 5'(e + 1) || bus.writeData !== rr_data[e])
        begin n_fail++; $display("FAIL rr_write k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.writeEn, bus.writeAdd, bus.writeData, e + 1, rr_data[e]); end
    end
    bus.req_valid = 3'b000;
    #1;
    n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready got=%b exp=000", bus.req_ready); end
    @(negedge clk);
    n_tests++; if (bus.writeEn !== 1'b0 || bus.writeAdd !== 5'd3) begin n_fail++; $display("FAIL idle_hold got=%b/%0d exp=0/3", bus.writeEn, bus.writeAdd); end
  endtask

  task automatic test_priority_after_idle();
    bus.req_valid = 3'b010;
    #1;
    n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL prio_g1 got=%b exp=010", bus.req_ready); end
    @(negedge clk) bus.req_valid = 3'b000;
    @(negedge clk) bus.req_valid = 3'b011;
    #1;
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL prio_wrap got=%b exp=001", bus.req_ready); end
    @(negedge clk) bus.req_valid = 3'b000;
  endtask

  task automatic test_raw_stall();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_stall got=%b exp=0", bus.issue_stall); end
    @(negedge clk);
    n_tests++; if (bus.busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy_set got=%h exp=00000020", bus.busy); end
    set_issue(1'b1, 5'd6, 5'd5, 5'd0);
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_c1 got=%b exp=1", bus.issue_stall); end
    @(negedge clk);
    set_req(WB_ALU, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b001;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1 || bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL raw_stall_c2 got=%b/%b exp=1/001", bus.issue_stall, bus.req_ready); end
    @(negedge clk) bus.req_valid = 3'b000;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1 || bus.writeEn !== 1'b1 || bus.writeAdd !== 5'd5)
      begin n_fail++; $display("FAIL raw_we_cycle got=%b/%b/%0d exp=1/1/5", bus.issue_stall, bus.writeEn, bus.writeAdd); end
    @(negedge clk);
    n_tests++; if (rf[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_rf5 got=%h exp=deadbeef", rf[5]); end
    n_tests++; if (bus.issue_stall !== 1'b0 || bus.busy !== 32'h0) begin n_fail++; $display("FAIL raw_release got=%b/%h exp=0/0", bus.issue_stall, bus.busy); end
    @(negedge clk) set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    n_tests++; if (bus.busy !== 32'h40) begin n_fail++; $display("FAIL raw_busy6 got=%h exp=00000040", bus.busy); end
    set_req(WB_ALU, 5'd6, 32'h6666);
    bus.req_valid = 3'b001;
    @(negedge clk) bus.req_valid = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clear got=%h exp=0", bus.busy); end
  endtask

  task automatic test_r0();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    set_req(WB_LOAD, 5'd0, 32'h1234);
    bus.req_valid = 3'b010;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0 || bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL r0_grant got=%b/%b exp=0/010", bus.issue_stall, bus.req_ready); end
    @(negedge clk);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.req_valid = 3'b000;
    n_tests++; if (bus.busy !== 32'h0 || bus.writeEn !== 1'b0) begin n_fail++; $display("FAIL r0_nowrite got=%h/%b exp=0/0", bus.busy, bus.writeEn); end
    n_tests++; if (bus.writeAdd !== 5'd0 || bus.writeData !== 32'h1234) begin n_fail++; $display("FAIL r0_load got=%0d/%h exp=0/1234", bus.writeAdd, bus.writeData); end
  endtask

  task automatic test_waw_set_clear();
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    @(negedge clk);
    set_req(WB_ALU, 5'd7, 32'h7777);
    bus.req_valid = 3'b001;
    #1;
    n_tests++; if (bus.issue_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", bus.issue_stall); end
    @(negedge clk);
    bus.req_valid = 3'b000;
    set_issue(1'b1, 5'd9, 5'd0, 5'd0);
    #1;
    n_tests++; if (bus.issue_stall !== 1'b0 || bus.busy !== 32'h80 || bus.writeEn !== 1'b1)
      begin n_fail++; $display("FAIL waw_pre got=%b/%h/%b exp=0/00000080/1", bus.issue_stall, bus.busy, bus.writeEn); end
    @(negedge clk) set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    n_tests++; if (bus.busy !== 32'h200) begin n_fail++; $display("FAIL waw_set_clear got=%h exp=00000200", bus.busy); end
    set_req(WB_ALU, 5'd9, 32'h9999);
    bus.req_valid = 3'b001;
    @(negedge clk) bus.req_valid = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL waw_cleanup got=%h exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    set_issue(1'b1, 5'd4, 5'd0, 5'd0);
    set_req(WB_ALU, 5'd3, 32'h3333);
    bus.req_valid = 3'b001;
    @(negedge clk);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.req_valid = 3'b000;
    n_tests++; if (bus.writeEn !== 1'b1 || bus.busy !== 32'h10) begin n_fail++; $display("FAIL rmid_pre got=%b/%h exp=1/00000010", bus.writeEn, bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.writeEn !== 1'b0 || bus.writeAdd !== 5'd0 || bus.writeData !== 32'd0 || bus.busy !== 32'd0)
      begin n_fail++; $display("FAIL rmid_clear got=%b/%0d/%h/%h exp=0/0/0/0", bus.writeEn, bus.writeAdd, bus.writeData, bus.busy); end
    @(negedge clk) rst_n = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_last got=%b exp=001", bus.req_ready); end
    @(negedge clk) bus.req_valid = 3'b000;
  endtask

  initial begin
    rr_data[0] = 32'hA0A0_0000;
    rr_data[1] = 32'hB1B1_0001;
    rr_data[2] = 32'hC2C2_0002;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    bus.req_valid = 3'b000;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset();
    test_round_robin();
    test_priority_after_idle();
    test_raw_stall();
    test_r0();
    test_waw_set_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
